// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared types and helpers for the gate-block self-test.
//   - state_e     : BIST sequencer states
//   - *_B         : bit positions of each gate output inside the 8-bit obs word
//   - expected_obs: golden obs word for a 2-bit {a,b} vector
//   - popcount8   : number of set bits in an 8-bit word
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int ANOT_B = 7;
  localparam int BNOT_B = 6;
  localparam int AND_B  = 5;
  localparam int NAND_B = 4;
  localparam int NOR_B  = 3;
  localparam int OR_B   = 2;
  localparam int XOR_B  = 1;
  localparam int XNOR_B = 0;

  localparam logic [1:0] VEC_LAST = 2'd3;

  // Golden obs word, built from the gate equations so the bit map and the
  // expected values cannot drift apart: 00->D9, 01->96, 10->56, 11->25.
  function automatic logic [7:0] expected_obs(input logic [1:0] vec);
    logic       a_s;
    logic       b_s;
    logic [7:0] exp_s;
    a_s            = vec[1];
    b_s            = vec[0];
    exp_s          = 8'h00;
    exp_s[ANOT_B]  = ~a_s;
    exp_s[BNOT_B]  = ~b_s;
    exp_s[AND_B]   = a_s & b_s;
    exp_s[NAND_B]  = ~(a_s & b_s);
    exp_s[NOR_B]   = ~(a_s | b_s);
    exp_s[OR_B]    = a_s | b_s;
    exp_s[XOR_B]   = a_s ^ b_s;
    exp_s[XNOR_B]  = ~(a_s ^ b_s);
    return exp_s;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] word);
    logic [3:0] cnt_s;
    cnt_s = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt_s = cnt_s + {3'd0, word[i]};
    end
    return cnt_s;
  endfunction

endpackage

// File: rtl/gate_bist_golden.sv
// gate_bist_golden: combinational compare stage.
//   vec      : current {a,b} stimulus vector (a is MSB)
//   obs      : sampled gate-block outputs
//   mask     : per-bit compare enable; masked bits never mismatch
//   mism     : (obs ^ expected) & mask
//   mism_cnt : number of mismatching bits (0..8)
module gate_bist_golden
  import gate_bist_pkg::*;
(
  input  logic [1:0] vec,
  input  logic [7:0] obs,
  input  logic [7:0] mask,
  output logic [7:0] mism,
  output logic [3:0] mism_cnt
);

  logic [7:0] expected_s;

  // Golden lookup, masked difference and its bit count.
  always_comb begin
    expected_s = expected_obs(vec);
    mism       = (obs ^ expected_s) & mask;
    mism_cnt   = popcount8(mism);
  end

endmodule

// File: rtl/gate_bist.sv
// gate_bist: BIST initiator for the two-input basic-gate block.
//   clk_in, rst_n_in   : clock, async active-low reset
//   start_in           : run request, honoured only while idle
//   a_out, b_out       : stimulus to the gate block (vector order 00,01,10,11)
//   obs_in             : gate outputs {anot,bnot,and,nand,nor,or,xor,xnor}
//   busy_out           : high from start acceptance through the DONE cycle
//   done_out           : one-cycle pulse at run end
//   pass_out           : last completed run had no mismatching bits
//   err_cnt_out        : saturating count of mismatching bits
//   fail_vec_out       : bit i set when vector i had any mismatch
//   first_fail_obs_out : obs_in captured at the first failing check
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter int         ERR_CNT_W     = 6,
  parameter logic [7:0] CHECK_MASK    = 8'hFF
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  output logic                 a_out,
  output logic                 b_out,
  input  logic [7:0]           obs_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 pass_out,
  output logic [ERR_CNT_W-1:0] err_cnt_out,
  output logic [3:0]           fail_vec_out,
  output logic [7:0]           first_fail_obs_out
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("gate_bist: SETTLE_CYCLES must be within 1..15");
  end
  if (ERR_CNT_W < 3 || ERR_CNT_W > 8) begin : g_bad_err_w
    $error("gate_bist: ERR_CNT_W must be within 3..8");
  end

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e                 state_r;
  state_e                 state_nxt_s;
  logic [1:0]             vec_idx_r;
  logic [3:0]             settle_cnt_r;
  logic                   a_r;
  logic                   b_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   pass_r;
  logic [ERR_CNT_W-1:0]   err_cnt_r;
  logic [3:0]             fail_vec_r;
  logic [7:0]             first_fail_r;
  logic [7:0]             mism_s;
  logic [3:0]             mism_cnt_s;
  logic [ERR_CNT_W+3:0]   err_sum_s;
  logic [ERR_CNT_W-1:0]   err_nxt_s;
  logic [1:0]             vec_inc_s;

  gate_bist_golden u_golden (
    .vec      (vec_idx_r),
    .obs      (obs_in),
    .mask     (CHECK_MASK),
    .mism     (mism_s),
    .mism_cnt (mism_cnt_s)
  );

  // Saturating accumulate: widen before adding so the clamp sees overflow.
  always_comb begin
    err_sum_s = {4'd0, err_cnt_r} + {{ERR_CNT_W{1'b0}}, mism_cnt_s};
    vec_inc_s = vec_idx_r + 2'd1;
    if (err_sum_s > {4'd0, {ERR_CNT_W{1'b1}}}) begin
      err_nxt_s = {ERR_CNT_W{1'b1}};
    end else begin
      err_nxt_s = err_sum_s[ERR_CNT_W-1:0];
    end
  end

  // Next-state decode of the run sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_in) begin
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_r == SETTLE_LAST) begin
          state_nxt_s = ST_CHECK;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_CHECK: begin
        if (vec_idx_r == VEC_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Stimulus, counters and result registers; all outputs come from here.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vec_idx_r    <= 2'd0;
      settle_cnt_r <= 4'd0;
      a_r          <= 1'b0;
      b_r          <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_cnt_r    <= {ERR_CNT_W{1'b0}};
      fail_vec_r   <= 4'd0;
      first_fail_r <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_in) begin
            busy_r       <= 1'b1;
            pass_r       <= 1'b0;
            err_cnt_r    <= {ERR_CNT_W{1'b0}};
            fail_vec_r   <= 4'd0;
            first_fail_r <= 8'h00;
            vec_idx_r    <= 2'd0;
            settle_cnt_r <= 4'd0;
            a_r          <= 1'b0;
            b_r          <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            settle_cnt_r <= 4'd0;
          end else begin
            settle_cnt_r <= settle_cnt_r + 4'd1;
          end
        end
        ST_CHECK: begin
          err_cnt_r <= err_nxt_s;
          if (mism_s != 8'h00) begin
            fail_vec_r[vec_idx_r] <= 1'b1;
            // No earlier vector failed this run -> this is the first failure.
            if (fail_vec_r == 4'd0) begin
              first_fail_r <= obs_in;
            end
          end
          if (vec_idx_r == VEC_LAST) begin
            done_r <= 1'b1;
            pass_r <= (err_nxt_s == {ERR_CNT_W{1'b0}});
            a_r    <= 1'b0;
            b_r    <= 1'b0;
          end else begin
            vec_idx_r <= vec_inc_s;
            a_r       <= vec_inc_s[1];
            b_r       <= vec_inc_s[0];
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign a_out              = a_r;
  assign b_out              = b_r;
  assign busy_out           = busy_r;
  assign done_out           = done_r;
  assign pass_out           = pass_r;
  assign err_cnt_out        = err_cnt_r;
  assign fail_vec_out       = fail_vec_r;
  assign first_fail_obs_out = first_fail_r;

endmodule
